// File: rtl/pipe_ctrl_pkg.sv
// Shared stall encodings and exception constants
// for the pipeline control slice.
package pipe_ctrl_pkg;

  localparam logic [5:0] StallNone = 6'b000000;
  localparam logic [5:0] StallId   = 6'b000111;
  localparam logic [5:0] StallEx   = 6'b001111;

  localparam logic [31:0] ExcEret   = 32'h0000000E;
  localparam logic [31:0] ExcVector = 32'h00000020;

endpackage

// File: rtl/pipe_ctrl_stall_counter.sv
// 16-bit saturating event counter; cleared only
// by the asynchronous active-low reset.
module stall_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != 16'hFFFF))
      count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= 16'd0;
    else      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard control: flush, multi-cycle EX
// stall sequencing, ID load-use stall, stall stats.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_stallreq,
  input  logic        ex_mc_req,
  input  logic [5:0]  ex_mc_cycles,
  input  logic [31:0] mem_excepttype,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        ex_mc_done,
  output logic        mc_busy,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MC_BUSY = 2'd1,
    MC_DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] stall_raw;
  logic       flush_raw;
  logic       done_raw;
  logic       exc;

  assign exc = |mem_excepttype;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_raw = StallNone;
    flush_raw = 1'b0;
    done_raw  = 1'b0;
    if (exc) begin
      flush_raw = 1'b1;
      state_d   = IDLE;
      cnt_d     = 6'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ex_mc_req && (ex_mc_cycles != 6'd0)) begin
            stall_raw = StallEx;
            if (ex_mc_cycles == 6'd1) begin
              state_d = MC_DONE;
            end else begin
              state_d = MC_BUSY;
              cnt_d   = ex_mc_cycles - 6'd1;
            end
          end else if (id_stallreq) begin
            stall_raw = StallId;
          end
        end
        MC_BUSY: begin
          stall_raw = StallEx;
          cnt_d     = cnt_q - 6'd1;
          // cnt_q <= 1 also guards against a stray zero count
          if (cnt_q <= 6'd1) begin
            state_d = MC_DONE;
            cnt_d   = 6'd0;
          end
        end
        MC_DONE: begin
          done_raw = 1'b1;
          state_d  = IDLE;
          if (id_stallreq)
            stall_raw = StallId;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 6'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall      = rst ? stall_raw : StallNone;
  assign flush      = rst & flush_raw;
  assign ex_mc_done = rst & done_raw;
  assign mc_busy    = (state_q == MC_BUSY);
  assign new_pc     = !flush ? 32'd0 :
                      (mem_excepttype == ExcEret) ? cp0_epc :
                      ExcVector;

  stall_counter u_stall_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall[0]),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        id_stallreq;
  logic        ex_mc_req;
  logic [5:0]  ex_mc_cycles;
  logic [31:0] mem_excepttype;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        ex_mc_done;
  logic        mc_busy;
  logic [15:0] stall_cnt;

  int checks;
  int failures;
  int exp_sc;

  pipe_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .id_stallreq    (id_stallreq),
    .ex_mc_req      (ex_mc_req),
    .ex_mc_cycles   (ex_mc_cycles),
    .mem_excepttype (mem_excepttype),
    .cp0_epc        (cp0_epc),
    .stall          (stall),
    .flush          (flush),
    .new_pc         (new_pc),
    .ex_mc_done     (ex_mc_done),
    .mc_busy        (mc_busy),
    .stall_cnt      (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat(input int v);
    return (v > 65535) ? 32'hFFFF : 32'(v);
  endfunction

  task automatic step(input string tag,
                      input logic req, input logic [5:0] n,
                      input logic id, input logic [31:0] exc,
                      input logic [31:0] epc,
                      input logic [5:0] e_stall, input logic e_flush,
                      input logic [31:0] e_pc, input logic e_done,
                      input logic e_busy);
    ex_mc_req      = req;
    ex_mc_cycles   = n;
    id_stallreq    = id;
    mem_excepttype = exc;
    cp0_epc        = epc;
    @(negedge clk);
    chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
    chk({tag, ".flush"}, 32'(flush), 32'(e_flush));
    chk({tag, ".new_pc"}, new_pc, e_pc);
    chk({tag, ".done"}, 32'(ex_mc_done), 32'(e_done));
    chk({tag, ".busy"}, 32'(mc_busy), 32'(e_busy));
    chk({tag, ".cnt"}, 32'(stall_cnt), sat(exp_sc));
    if (e_stall[0]) exp_sc++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".stall"}, 32'(stall), 32'd0);
    chk({tag, ".flush"}, 32'(flush), 32'd0);
    chk({tag, ".new_pc"}, new_pc, 32'd0);
    chk({tag, ".done"}, 32'(ex_mc_done), 32'd0);
    chk({tag, ".busy"}, 32'(mc_busy), 32'd0);
    chk({tag, ".cnt"}, 32'(stall_cnt), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_sc   = 0;
    rst            = 1'b0;
    id_stallreq    = 1'b1;
    ex_mc_req      = 1'b1;
    ex_mc_cycles   = 6'd5;
    mem_excepttype = 32'h8;
    cp0_epc        = 32'h1234;
    #2;
    chk_reset_outs("rst");
    @(posedge clk);
    #1;
    rst = 1'b1;

    step("idle", 0, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0);
    // N=5, request held high throughout
    step("n5c1", 1, 5, 0, 0, 0, 6'h0F, 0, 0, 0, 0);
    step("n5c2", 1, 5, 0, 0, 0, 6'h0F, 0, 0, 0, 1);
    step("n5c3", 1, 5, 0, 0, 0, 6'h0F, 0, 0, 0, 1);
    step("n5c4", 1, 5, 0, 0, 0, 6'h0F, 0, 0, 0, 1);
    step("n5c5", 1, 5, 0, 0, 0, 6'h0F, 0, 0, 0, 1);
    step("n5c6", 1, 5, 0, 0, 0, 6'h00, 0, 0, 1, 0);
    step("n5c7", 0, 5, 0, 0, 0, 6'h00, 0, 0, 0, 0);

    step("n1a", 1, 1, 0, 0, 0, 6'h0F, 0, 0, 0, 0);
    step("n1b", 1, 0, 0, 0, 0, 6'h00, 0, 0, 1, 0);
    step("n0a", 1, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0);
    step("n0b", 1, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0);

    step("idb1", 1, 3, 1, 0, 0, 6'h0F, 0, 0, 0, 0);
    step("idb2", 0, 3, 1, 0, 0, 6'h0F, 0, 0, 0, 1);
    step("idb3", 0, 3, 1, 0, 0, 6'h0F, 0, 0, 0, 1);
    step("idd",  0, 3, 1, 0, 0, 6'h07, 0, 0, 1, 0);
    step("idi",  0, 3, 1, 0, 0, 6'h07, 0, 0, 0, 0);

    step("ex1", 1, 6, 0, 0, 0, 6'h0F, 0, 0, 0, 0);
    step("ex2", 1, 6, 0, 0, 0, 6'h0F, 0, 0, 0, 1);
    step("ex3", 1, 6, 0, 0, 0, 6'h0F, 0, 0, 0, 1);
    step("exf", 1, 6, 1, 32'h8, 0, 6'h00, 1, 32'h20, 0, 1);
    step("ex5", 0, 6, 0, 0, 0, 6'h00, 0, 0, 0, 0);
    step("ex6", 0, 6, 0, 0, 0, 6'h00, 0, 0, 0, 0);

    step("eret", 1, 4, 1, 32'hE, 32'h00400100,
         6'h00, 1, 32'h00400100, 0, 0);
    step("eret2", 0, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0);
    step("exid", 0, 0, 1, 32'h3, 32'h00400100,
         6'h00, 1, 32'h20, 0, 0);

    step("ar1", 1, 10, 0, 0, 0, 6'h0F, 0, 0, 0, 0);
    step("ar2", 1, 10, 0, 0, 0, 6'h0F, 0, 0, 0, 1);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outs("arst");
    @(posedge clk);
    #1;
    rst    = 1'b1;
    exp_sc = 0;
    step("ar3", 0, 10, 0, 0, 0, 6'h00, 0, 0, 0, 0);
    step("ar4", 0, 10, 0, 0, 0, 6'h00, 0, 0, 0, 0);

    ex_mc_req      = 1'b0;
    id_stallreq    = 1'b1;
    mem_excepttype = 32'd0;
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk);
    end
    #1;
    exp_sc += 70000;
    step("sat1", 0, 0, 1, 0, 0, 6'h07, 0, 0, 0, 0);
    step("sat2", 0, 0, 1, 0, 0, 6'h07, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
